// File: rtl/eoc_monitor_pkg.sv
// Shared types and exit-code constants for the end-of-computation monitor.
package eoc_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE,
    TIMEOUT
  } eoc_state_e;

  // Exit codes as plain ints; sign-extended to the status width where used.
  localparam int EXIT_SUCCESS = 0;
  localparam int EXIT_FAIL    = 1;
  localparam int EXIT_ERROR   = -1;

endpackage

// File: rtl/eoc_sync.sv
// Multi-flop synchronizer for one asynchronous done level.
module eoc_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the asynchronous level through the flop chain.
  always_ff @(posedge clk) begin
    if (rst) chain <= '0;
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/eoc_monitor.sv
// Multi-channel end-of-computation monitor with per-channel exit status and
// a prescaled watchdog.
module eoc_monitor
  import eoc_monitor_pkg::*;
#(
  parameter int unsigned NUM_CH      = 1,
  parameter int unsigned STATUS_W    = 32,
  parameter int unsigned TIMEOUT_W   = 32,
  parameter int unsigned PRESCALE    = 25,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [TIMEOUT_W-1:0] timeout_ticks_i,
  input  logic [NUM_CH-1:0]    done_i,
  input  logic                 status_we_i,
  input  logic [CH_W-1:0]      status_ch_i,
  input  logic [STATUS_W-1:0]  status_data_i,
  output logic                 busy_o,
  output logic                 finished_o,
  output logic                 timed_out_o,
  output logic                 pass_o,
  output logic [NUM_CH-1:0]    done_mask_o,
  output logic [NUM_CH-1:0]    fail_mask_o,
  output logic [TIMEOUT_W-1:0] elapsed_o
);

  localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  eoc_state_e           state_q, state_d;
  logic [NUM_CH-1:0]    sync_done;
  logic [NUM_CH-1:0]    done_mask_q, done_mask_d;
  logic [STATUS_W-1:0]  status_q [NUM_CH];
  logic [TIMEOUT_W-1:0] elapsed_q, elapsed_d;
  logic [TIMEOUT_W-1:0] limit_q;
  logic [PS_W-1:0]      presc_q;
  logic                 tick;
  logic                 arm;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_sync
    eoc_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (done_i[g]),
      .q   (sync_done[g])
    );
  end

  assign arm = start_i && (state_q != RUN);

  // Next-state, next done mask and next tick count.
  always_comb begin
    tick        = (presc_q == PS_W'(PRESCALE - 1));
    done_mask_d = done_mask_q | sync_done;
    elapsed_d   = elapsed_q;
    state_d     = state_q;
    if (tick && (elapsed_q != '1)) elapsed_d = elapsed_q + 1'b1;
    case (state_q)
      RUN: begin
        // All-done wins over a coincident watchdog expiry.
        if (&done_mask_d)
          state_d = DONE;
        else if ((limit_q != '0) && (elapsed_d == limit_q))
          state_d = TIMEOUT;
      end
      default: if (start_i) state_d = RUN;
    endcase
  end

  // State, done mask, watchdog counters and latched limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      done_mask_q <= '0;
      elapsed_q   <= '0;
      presc_q     <= '0;
      limit_q     <= '0;
    end else begin
      state_q <= state_d;
      if (arm) begin
        done_mask_q <= '0;
        elapsed_q   <= '0;
        presc_q     <= '0;
        limit_q     <= timeout_ticks_i;
      end else if (state_q == RUN) begin
        done_mask_q <= done_mask_d;
        elapsed_q   <= elapsed_d;
        presc_q     <= tick ? '0 : presc_q + 1'b1;
      end
    end
  end

  // Per-channel exit status; out-of-range channel numbers match no entry.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (rst || arm)
        status_q[i] <= STATUS_W'(EXIT_ERROR);
      else if ((state_q == RUN) && status_we_i && (status_ch_i == CH_W'(i)))
        status_q[i] <= status_data_i;
    end
  end

  // Failure flags straight from the status registers.
  always_comb begin
    fail_mask_o = '0;
    for (int unsigned i = 0; i < NUM_CH; i++)
      fail_mask_o[i] = (status_q[i] != STATUS_W'(EXIT_SUCCESS));
  end

  assign busy_o      = (state_q == RUN);
  assign finished_o  = (state_q == DONE) || (state_q == TIMEOUT);
  assign timed_out_o = (state_q == TIMEOUT);
  assign pass_o      = (state_q == DONE) && (fail_mask_o == '0);
  assign done_mask_o = done_mask_q;
  assign elapsed_o   = elapsed_q;

endmodule

// File: doc/eoc_monitor.md
# eoc_monitor

Synthesizable end-of-computation monitor for PULPino test harnesses, both simulation and FPGA. It watches `NUM_CH` asynchronous done lines, such as `gpio_out8` per core or instance, and collects one exit-status word per channel from a simple write port. It enforces a prescaled watchdog and reports pass, fail or timeout. It generalises the single-line "wait for done, then check return code" flow to multiple channels, adding a hardware timeout and per-channel verdicts.

## Interface
Parameters:
- `NUM_CH`, 1: number of monitored channels (1..16).
- `STATUS_W`, 32: width of an exit-status word.
- `TIMEOUT_W`, 32: width of the tick counter and timeout limit.
- `PRESCALE`, 25: `clk` cycles per watchdog tick (25 gives 1 µs at 25 MHz); must be ≥1.
- `SYNC_STAGES`, 2: synchronizer depth on `done_i` (≥2).

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `start_i`, in, 1: single-cycle arm pulse.
- `timeout_ticks_i`, in, `TIMEOUT_W`: watchdog limit in ticks; 0 disables the watchdog. Sampled at the start pulse.
- `done_i`, in, `NUM_CH`: asynchronous done levels.
- `status_we_i`, in, 1: status write strobe.
- `status_ch_i`, in, `$clog2(NUM_CH)` (min 1): target channel of the write.
- `status_data_i`, in, `STATUS_W`: exit code; 0 means success.
- `busy_o`, out, 1: monitor is in the RUN state.
- `finished_o`, out, 1: monitor is in DONE or TIMEOUT.
- `timed_out_o`, out, 1: monitor is in TIMEOUT.
- `pass_o`, out, 1: DONE, with every status word equal to 0.
- `done_mask_o`, out, `NUM_CH`: channels whose done has been latched.
- `fail_mask_o`, out, `NUM_CH`: channels whose status word is non-zero.
- `elapsed_o`, out, `TIMEOUT_W`: ticks elapsed since arm; saturates at all-ones.

## Operation
- FSM states are IDLE, RUN, DONE and TIMEOUT. Reset state is IDLE.
- Arming (`start_i` in IDLE, DONE or TIMEOUT):
  - go to RUN;
  - clear `done_mask_o`, `elapsed_o` and the prescaler;
  - preset every status word to all-ones (`EXIT_ERROR`, −1);
  - latch `timeout_ticks_i`.
  - `start_i` while in RUN is ignored.
- Done latching in RUN: a done bit latches on any cycle its synchronized level is 1. This is level-sensitive, so a line already high at arm latches on the first RUN cycle. Latched bits stay set until the next arm. Done levels are ignored outside RUN.
- Status writes are accepted only in RUN; the last write wins. Writes with `status_ch_i` ≥ `NUM_CH` are dropped. Writes outside RUN are dropped.
- Prescaler in RUN: counts 0..`PRESCALE`−1, and each wrap increments `elapsed_o`. `elapsed_o` saturates at all-ones.
- RUN → DONE when the next-state `done_mask` is all-ones.
- RUN → TIMEOUT when the limit is non-zero, the next-state `elapsed_o` equals the limit, and not all channels are done.
- DONE has priority if both transitions occur in the same cycle.
- DONE and TIMEOUT hold all outputs until the next arm or `rst`.
- `fail_mask_o[i]` is `status[i] != 0`. It is combinational from the status registers and is valid in every state.
- `pass_o` is DONE && (`fail_mask_o` == 0). `pass_o` is never asserted in TIMEOUT.

## Timing
- Reset values:
  - all flags are 0;
  - `done_mask_o` is 0;
  - `elapsed_o` is 0;
  - status words are all-ones, so `fail_mask_o` is all-ones;
  - synchronizers are cleared.
- `start_i` at edge N gives `busy_o` = 1 after edge N.
- A `done_i` rise, once stable, sets the `done_mask_o` bit after `SYNC_STAGES`+1 edges.
- `finished_o` rises on the same edge that the last mask bit sets.
- A status write in the final RUN cycle, i.e. coincident with the last done, is captured. `pass_o` reflects it on that same edge.
- The first tick occurs `PRESCALE` cycles after arm. With limit L, TIMEOUT is entered on the edge `L·PRESCALE` cycles after arm.
- `rst` mid-RUN returns the block to IDLE with reset values on the next edge.

## Structure
- `eoc_monitor_pkg` holds:
  - the `eoc_state_e` enum (IDLE/RUN/DONE/TIMEOUT);
  - `EXIT_SUCCESS` = 0, `EXIT_FAIL` = 1 and `EXIT_ERROR` = −1 as `STATUS_W`-independent localparam ints, sign-extended where used.
- One sub-module, `eoc_sync`: a `SYNC_STAGES`-deep flop chain with synchronous active-high reset. It is instantiated once per channel through a generate loop.

## Test plan
- `NUM_CH`=1, limit 0. Arm, write 0 to channel 0, raise `done_i` → `finished_o` after 3 edges, `pass_o`=1, `timed_out_o`=0.
- `NUM_CH`=4. Dones arrive staggered; channel 2 writes 5 and the others write 0 → `finished_o` only after the 4th done, `pass_o`=0, `fail_mask_o`=4'b0100.
- `PRESCALE`=4, limit 10, done never raised → `timed_out_o` exactly 40 cycles after arm, `elapsed_o`=10, `fail_mask_o`=all-ones.
- Last done and the timeout in the same cycle → DONE, not TIMEOUT. Status write coincident with the last done → captured.
- `done_i` already high before arm → latches on the first RUN cycle. Re-arm from DONE clears the masks, and `elapsed_o` restarts at 0.
- `rst` asserted mid-RUN and writes to `status_ch_i`=`NUM_CH` → IDLE with reset values; the out-of-range write is ignored.
